// File: rtl/fp8_prod_accum.sv
// rtl/fp8_prod_accum.sv - FP8 (E4M3) product to fixed-point accumulator, optional saturation via FP8_ACC_SAT_EN
module fp8_prod_accum #(
    parameter int EXP_BITS      = 4,
    parameter int MANTISSA_BITS = 3,
    parameter int BIAS          = 7,
    parameter int ACC_W         = 24,
    parameter int CNT_W         = 8
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_start,
    input  logic [CNT_W-1:0]        i_len,
    input  logic                    i_in_valid,
    input  logic [7:0]              i_in_data,
    output logic                    o_in_ready,
    output logic                    o_out_valid,
    output logic [ACC_W-1:0]        o_out_acc,
    input  logic                    i_out_ready,
    output logic                    o_busy,
    output logic                    o_ovf
);

    // Largest shifted magnitude: {1,M} moved up by the maximum exponent code.
    localparam int MAG_W = MANTISSA_BITS + 1 + (1 << EXP_BITS) - 1;

    if ((1 + EXP_BITS + MANTISSA_BITS) != 8 || BIAS >= (1 << EXP_BITS) || ACC_W <= MAG_W) begin : g_bad_cfg
        $error("fp8_prod_accum: inconsistent format parameters");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic signed [ACC_W-1:0]  r_acc;
    logic [CNT_W-1:0]         r_cnt;
    logic                     r_ovf;

    logic [EXP_BITS-1:0]      w_exp;
    logic [MANTISSA_BITS-1:0] w_man;
    logic                     w_sign;
    logic [MAG_W-1:0]         w_mag;
    logic signed [ACC_W:0]    w_mag_ext;
    logic signed [ACC_W:0]    w_term;
    logic signed [ACC_W:0]    w_sum;
    logic                     w_sum_ovf;
    logic signed [ACC_W-1:0]  w_acc_nxt;
    logic                     w_hs;

    assign w_sign = i_in_data[7];
    assign w_exp  = i_in_data[MANTISSA_BITS +: EXP_BITS];
    assign w_man  = i_in_data[MANTISSA_BITS-1:0];

    // Fixed-point LSB is 2^-(BIAS+MANTISSA_BITS), so the exponent code is the shift directly.
    assign w_mag     = (w_exp == '0) ? '0 : (MAG_W'({1'b1, w_man}) << w_exp);
    assign w_mag_ext = $signed({{(ACC_W + 1 - MAG_W){1'b0}}, w_mag});
    assign w_term    = w_sign ? -w_mag_ext : w_mag_ext;

    assign w_sum     = {r_acc[ACC_W-1], r_acc} + w_term;
    assign w_sum_ovf = w_sum[ACC_W] ^ w_sum[ACC_W-1];

`ifdef FP8_ACC_SAT_EN
    always_comb begin
        w_acc_nxt = w_sum[ACC_W-1:0];
        if (w_sum_ovf) begin
            w_acc_nxt = w_sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        end
    end
`else
    assign w_acc_nxt = w_sum[ACC_W-1:0];
`endif

    assign w_hs = (r_state == S_ACCUM) && i_in_valid;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_state_nxt = (i_len == '0) ? S_DONE : S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (i_in_valid && r_cnt == CNT_W'(1)) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (i_out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_acc <= '0;
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end else if (r_state == S_IDLE && i_start) begin
            r_acc <= '0;
            r_cnt <= i_len;
            r_ovf <= 1'b0;
        end else if (w_hs) begin
            r_acc <= w_acc_nxt;
            r_cnt <= r_cnt - CNT_W'(1);
            if (w_sum_ovf) begin
                r_ovf <= 1'b1;
            end
        end
    end

    assign o_in_ready  = (r_state == S_ACCUM);
    assign o_out_valid = (r_state == S_DONE);
    assign o_busy      = (r_state != S_IDLE);
    assign o_ovf       = r_ovf;
    assign o_out_acc   = r_acc;

endmodule

// File: doc/fp8_prod_accum.md
Name: fp8_prod_accum

Overview:
- Downstream consumer of the combinational FP8 (E4M3, bias 7) multiplier output byte.
- Accepts a stream of FP8 products over a valid/ready handshake and converts each to signed fixed point.
- Accumulates a programmed number of terms, then presents the sum on a valid/ready output port.
- Forms the accumulate half of a dot-product datapath.

Parameters:
- EXP_BITS, 4, exponent field width of input byte
- MANTISSA_BITS, 3, mantissa field width of input byte
- BIAS, 7, exponent bias
- ACC_W, 24, signed accumulator width; LSB weight = 2^-(BIAS+MANTISSA_BITS) = 2^-10
- CNT_W, 8, width of term-count input

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin a new accumulation; honoured only in IDLE
- len  in  CNT_W  number of terms, sampled on accepted start
- in_valid  in  1  product byte valid
- in_data  in  8  FP8 product {S, E[3:0], M[2:0]}
- in_ready  out  1  block accepts a product this cycle
- out_valid  out  1  accumulated result valid
- out_acc  out  ACC_W  signed two's-complement sum
- out_ready  in  1  consumer accepts result
- busy  out  1  high in ACCUM or DONE
- ovf  out  1  sticky overflow flag for current accumulation

Behaviour:
- Reset values (asynchronous, immediate on rst_n low): state=IDLE, acc=0, cnt=0, ovf=0, in_ready=0, out_valid=0, busy=0. Reset mid-operation discards all partial state.
- Term conversion (combinational):
  - E==0: term = 0. Mantissa ignored; no subnormal support, matching the multiplier.
  - Otherwise mag = {1'b1, M} << E, 19 bits unsigned; E=15, M=7 gives 491520 (480.0).
  - Term = S ? -mag : +mag, sign-extended to ACC_W+1 bits.
  - No NaN/Inf special-casing; all codes with E!=0 are treated as normal numbers.
- FSM states: IDLE, ACCUM, DONE. All outputs are registered or decoded from state only.
- IDLE:
  - in_ready=0, out_valid=0; out_acc holds the last sum.
  - start=1 with len!=0: acc<=0, ovf<=0, cnt<=len, go to ACCUM.
  - start=1 with len==0: acc<=0, ovf<=0, go to DONE, so out_valid is high the next cycle.
- ACCUM:
  - in_ready=1.
  - Handshake (in_valid & in_ready): acc<=acc+term, cnt<=cnt-1.
  - Handshake with cnt==1: go to DONE on the same edge.
  - in_valid low: state holds, no change.
- DONE:
  - out_valid=1; out_acc stable while out_ready is low.
  - out_valid & out_ready: go to IDLE; out_valid is low the next cycle.
- Latency: out_valid rises on the edge after the final input handshake. One term per cycle sustained.
- start while in ACCUM or DONE is ignored; len is not re-sampled.
- Overflow: the (ACC_W+1)-bit sum is out of the ACC_W signed range → ovf<=1 (sticky until next accepted start). Stored value is set by the optional feature.
- out_acc = acc register directly.

Optional Feature:
- Macro: FP8_ACC_SAT_EN.
- Defined: on overflow, acc clamps to +2^(ACC_W-1)-1 or -2^(ACC_W-1) according to the true sum sign. Later terms continue from the clamped value.
- Undefined: acc takes the low ACC_W bits of the sum (two's-complement wrap).
- ovf behaviour is identical in both builds.

Test Plan:
- len=3, products 0x38, 0x38, 0x40 (1.0, 1.0, 2.0) → out_valid one cycle after third handshake, out_acc=4096, ovf=0.
- len=3, products 0x38, 0xB8, 0x05 (1.0, -1.0, E=0 zero) → out_acc=0; the E=0 term still counts toward len.
- len=4 with in_valid gaps of 2 cycles, out_ready low 5 cycles in DONE, start pulsed during DONE → sum unaffected by gaps; out_valid/out_acc stable; start ignored; IDLE the cycle after out_ready.
- len=20, all 0x7F (480.0) → true sum 9830400. FP8_ACC_SAT_EN: out_acc=8388607, ovf=1. Without macro: out_acc=-6946816, ovf=1. Next start clears ovf.
- start with len=0 → out_valid the next cycle, out_acc=0, in_ready never high.
- rst_n low after 2 of 5 terms → in_ready, out_valid, busy, ovf, out_acc drop to 0 without a clock edge. After release, start len=1 with 0x38 → out_acc=1024.
